debug_controller: RTL and testbench
===================================

DEBUG_CONTROLLER -- requirements
Module: debug_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: CLK input 1 (rising-edge clock); RST input 1 (synchronous, active-high reset).
REQ-002 SHALL have ports:
- HLT  input  1  halt request from debug host.
- DBG_ADDR  input  12  debug read address.
- instr_done  input  1  CPU retired an instruction this cycle.
- pc_in  input  32  current CPU PC.
- rf_addr  output  5  register-file debug read port address.
- rf_rdata  input  32  register-file data, combinational from rf_addr.
- mem_rd_en  output  1  data-memory debug read strobe.
- mem_addr  output  10  data-memory word address.
- mem_rdata  input  32  memory data, valid the cycle after mem_rd_en.
- cpu_stall  output  1  freezes CPU fetch/commit.
- HALTED  output  1  CPU frozen at instruction boundary.
- DATA  output  32  last debug read result.
- DATA_VALID  output  1  DATA corresponds to current latched address.
- DBG_PC  output  32  PC captured at halt.

Function
REQ-003 SHALL implement states RUN, DRAIN, IDLE, RD_RF, RD_MEM, MEM_WAIT.
REQ-004 RUN: HLT=1 -> DRAIN with cpu_stall=1 from the next cycle.
REQ-005 DRAIN: instr_done=1 -> IDLE, HALTED=1, DBG_PC<=pc_in; HLT=0 before instr_done -> RUN, cpu_stall=0.
REQ-006 Address map: 0x000-0x01F register r0-r31; 0x020-0x41F memory word (DBG_ADDR-32); 0x420-0xFFF unmapped.
REQ-007 IDLE: on entry, or when DBG_ADDR differs from latched address, latch DBG_ADDR and clear DATA_VALID; then go RD_RF (register), RD_MEM (memory), or load DATA=0, DATA_VALID=1 and stay IDLE (unmapped).
REQ-008 RD_RF: rf_addr=latched[4:0]; DATA<=rf_rdata, DATA_VALID<=1, -> IDLE; latency 2 edges after address change.
REQ-009 RD_MEM: mem_rd_en=1 for exactly one cycle, mem_addr=latched-32 (10 bits) -> MEM_WAIT; MEM_WAIT: DATA<=mem_rdata, DATA_VALID<=1 -> IDLE; latency 3 edges.
REQ-010 An address change during RD_RF/RD_MEM/MEM_WAIT SHALL NOT abort the read; it is detected in IDLE and a new read launched.
REQ-011 HLT=0 in IDLE -> RUN, HALTED=0, cpu_stall=0 next cycle; HLT=0 during a read completes the read, returning via IDLE then RUN.
REQ-012 DATA and DBG_PC SHALL hold their last values outside loads; mem_rd_en=0 in all states except RD_MEM.
REQ-013 rf_addr and mem_addr SHALL be driven from the latched address only (no combinational path from DBG_ADDR).

Reset
REQ-014 RST=1 SHALL override all events, including a read in progress: state RUN, cpu_stall=0, HALTED=0, mem_rd_en=0, DATA=0, DATA_VALID=0, DBG_PC=0, latched address=0.
REQ-015 HLT=1 with RST=1 SHALL be ignored; DRAIN is entered on the first edge with RST=0 and HLT=1.

Configuration
REQ-016 Macro DBG_DRAIN_TIMEOUT_EN: when defined, a 4-bit counter in DRAIN forces IDLE (HALTED=1, DBG_PC<=pc_in) after 16 cycles without instr_done; counter cleared on DRAIN entry.
REQ-017 Without DBG_DRAIN_TIMEOUT_EN: DRAIN waits indefinitely for instr_done or HLT=0; no counter logic.

Structure
REQ-018 Shared package SHALL hold the state enum, region bases (RF_BASE=0x000, MEM_BASE=0x020, MEM_END=0x41F) and the timeout constant 16.
REQ-019 Address decode (region + offset) SHALL be one sub-module, debug_addr_decode; all other logic stays in debug_controller.

Verification
REQ-020 Halt: HLT=1, instr_done pulsed 3 cycles later -> HALTED=1 on that edge, DBG_PC = pc_in sampled there (e.g. 0x0000_0040).
REQ-021 Register read: halted, DBG_ADDR=31, rf_rdata=0x0000_00AB -> DATA=0xAB, DATA_VALID=1 two edges later.
REQ-022 Sweep 31->38 every 5 cycles across the register/memory boundary: DBG_ADDR=32 -> mem_rd_en one cycle with mem_addr=0; DATA=mem word 0 after 3 edges; DBG_ADDR=38 -> mem_addr=6.
REQ-023 DBG_ADDR=0x420 -> DATA=0, DATA_VALID=1, no mem_rd_en.
REQ-024 RST=1 asserted during MEM_WAIT -> next edge all outputs at reset values, state RUN; HLT=0 in IDLE -> cpu_stall=0 next edge.
REQ-025 With DBG_DRAIN_TIMEOUT_EN, HLT=1 and no instr_done -> HALTED=1 after 16 DRAIN cycles; without it, HALTED stays 0 for at least 100 cycles.

Source files
------------

// File: rtl/debug_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debug_controller_pkg
//  Description : Shared types and constants for the debug controller:
//                controller state encoding, debug address-map regions and
//                the optional drain-timeout length.
//  Revision    : 1.0 - initial release
// ============================================================================
package debug_controller_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        DRAIN    = 3'd1,
        IDLE     = 3'd2,
        RD_RF    = 3'd3,
        RD_MEM   = 3'd4,
        MEM_WAIT = 3'd5
    } dbg_state_t;

    typedef enum logic [1:0] {
        REGION_RF       = 2'd0,
        REGION_MEM      = 2'd1,
        REGION_UNMAPPED = 2'd2
    } dbg_region_t;

    // Debug address map: registers first, then 1024 data-memory words.
    localparam logic [11:0] RF_BASE  = 12'h000;
    localparam logic [11:0] MEM_BASE = 12'h020;
    localparam logic [11:0] MEM_END  = 12'h41F;

    // DRAIN cycles without a retired instruction before a forced halt.
    localparam int DRAIN_TIMEOUT = 16;

endpackage
`default_nettype wire

// File: rtl/debug_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : debug_addr_decode
//  Description : Splits a 12-bit debug address into a region (register file,
//                data memory, unmapped) and a 10-bit offset inside it.
//  Ports       : addr   - debug address
//                region - decoded region
//                offset - register index / memory word address
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_addr_decode
    import debug_controller_pkg::*;
(
    input  logic [11:0] addr,
    output dbg_region_t region,
    output logic [9:0]  offset
);

    // Offsets are computed modulo 1024; within a mapped region the true
    // offset always fits in 10 bits, so the upper address bits are not needed.
    always_comb begin
        region = REGION_UNMAPPED;
        offset = addr[9:0] - RF_BASE[9:0];
        if (addr < MEM_BASE) begin
            region = REGION_RF;
            offset = addr[9:0] - RF_BASE[9:0];
        end else if (addr <= MEM_END) begin
            region = REGION_MEM;
            offset = addr[9:0] - MEM_BASE[9:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/debug_controller.sv
`default_nettype none
// ============================================================================
//  Module      : debug_controller
//  Description : Halts the CPU at an instruction boundary on host request and
//                serves debug reads of the register file and data memory
//                while halted.
//  Ports       : CLK, RST      - clock, synchronous active-high reset
//                HLT           - halt request from the debug host
//                DBG_ADDR      - debug read address
//                instr_done    - CPU retired an instruction this cycle
//                pc_in         - current CPU PC
//                rf_addr       - register-file debug read address
//                rf_rdata      - register-file data (combinational)
//                mem_rd_en     - data-memory debug read strobe
//                mem_addr      - data-memory word address
//                mem_rdata     - memory data, valid cycle after mem_rd_en
//                cpu_stall     - freezes CPU fetch/commit
//                HALTED        - CPU frozen at instruction boundary
//                DATA          - last debug read result
//                DATA_VALID    - DATA matches the latched address
//                DBG_PC        - PC captured at halt
//  Config      : DBG_DRAIN_TIMEOUT_EN - when defined, DRAIN forces a halt
//                after DRAIN_TIMEOUT cycles without a retired instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_controller
    import debug_controller_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        HLT,
    input  logic [11:0] DBG_ADDR,
    input  logic        instr_done,
    input  logic [31:0] pc_in,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_rdata,
    output logic        mem_rd_en,
    output logic [9:0]  mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        cpu_stall,
    output logic        HALTED,
    output logic [31:0] DATA,
    output logic        DATA_VALID,
    output logic [31:0] DBG_PC
);

    dbg_state_t  r_state;
    logic [11:0] r_lat_addr;
    logic [9:0]  r_lat_offset;   // decoded offset captured with r_lat_addr
    logic        r_entry_read;   // first IDLE cycle after a halt reads unconditionally
    logic        r_cpu_stall;
    logic        r_halted;
    logic        r_mem_rd_en;
    logic        r_data_valid;
    logic [31:0] r_data;
    logic [31:0] r_dbg_pc;

    dbg_region_t w_region;
    logic [9:0]  w_offset;
    logic        w_addr_changed;
    logic        w_drain_done;

    debug_addr_decode u_addr_decode (
        .addr   (DBG_ADDR),
        .region (w_region),
        .offset (w_offset)
    );

    assign w_addr_changed = (DBG_ADDR != r_lat_addr);

`ifdef DBG_DRAIN_TIMEOUT_EN
    logic [3:0] r_drain_cnt;
    logic       w_drain_timeout;

    assign w_drain_timeout = (r_drain_cnt == 4'(DRAIN_TIMEOUT - 1));
    // A retired instruction wins; a dropped HLT beats the timeout.
    assign w_drain_done    = instr_done || (HLT && w_drain_timeout);
`else
    assign w_drain_done    = instr_done;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= RUN;
            r_lat_addr   <= 12'd0;
            r_lat_offset <= 10'd0;
            r_entry_read <= 1'b0;
            r_cpu_stall  <= 1'b0;
            r_halted     <= 1'b0;
            r_mem_rd_en  <= 1'b0;
            r_data_valid <= 1'b0;
            r_data       <= 32'd0;
            r_dbg_pc     <= 32'd0;
`ifdef DBG_DRAIN_TIMEOUT_EN
            r_drain_cnt  <= 4'd0;
`endif
        end else begin
            r_mem_rd_en <= 1'b0;
            case (r_state)
                RUN: begin
                    if (HLT) begin
                        r_state     <= DRAIN;
                        r_cpu_stall <= 1'b1;
`ifdef DBG_DRAIN_TIMEOUT_EN
                        r_drain_cnt <= 4'd0;
`endif
                    end
                end
                DRAIN: begin
                    if (w_drain_done) begin
                        r_state      <= IDLE;
                        r_halted     <= 1'b1;
                        r_dbg_pc     <= pc_in;
                        r_entry_read <= 1'b1;
                    end else if (!HLT) begin
                        r_state     <= RUN;
                        r_cpu_stall <= 1'b0;
                    end
`ifdef DBG_DRAIN_TIMEOUT_EN
                    else begin
                        r_drain_cnt <= r_drain_cnt + 4'd1;
                    end
`endif
                end
                IDLE: begin
                    if (!HLT) begin
                        r_state     <= RUN;
                        r_halted    <= 1'b0;
                        r_cpu_stall <= 1'b0;
                    end else if (r_entry_read || w_addr_changed) begin
                        r_entry_read <= 1'b0;
                        r_lat_addr   <= DBG_ADDR;
                        r_lat_offset <= w_offset;
                        r_data_valid <= 1'b0;
                        case (w_region)
                            REGION_RF: r_state <= RD_RF;
                            REGION_MEM: begin
                                r_state     <= RD_MEM;
                                // Registered strobe: high exactly during RD_MEM.
                                r_mem_rd_en <= 1'b1;
                            end
                            default: begin
                                // Unmapped addresses complete immediately.
                                r_data       <= 32'd0;
                                r_data_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                RD_RF: begin
                    r_data       <= rf_rdata;
                    r_data_valid <= 1'b1;
                    r_state      <= IDLE;
                end
                RD_MEM: begin
                    r_state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    r_data       <= mem_rdata;
                    r_data_valid <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    // Read-port addresses come only from the latched copy of DBG_ADDR.
    assign rf_addr    = r_lat_offset[4:0];
    assign mem_addr   = r_lat_offset;
    assign mem_rd_en  = r_mem_rd_en;
    assign cpu_stall  = r_cpu_stall;
    assign HALTED     = r_halted;
    assign DATA       = r_data;
    assign DATA_VALID = r_data_valid;
    assign DBG_PC     = r_dbg_pc;

endmodule
`default_nettype wire

// File: tb/tb_debug_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_controller
//  Description : Self-checking bench for debug_controller. Register file and
//                data memory are modelled as arrays; each debug read is
//                predicted from the address map (value and latency by region).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_controller;

    logic        CLK = 1'b0;
    logic        RST;
    logic        HLT;
    logic [11:0] DBG_ADDR;
    logic        instr_done;
    logic [31:0] pc_in;
    logic [4:0]  rf_addr;
    logic [31:0] rf_rdata;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        cpu_stall;
    logic        HALTED;
    logic [31:0] DATA;
    logic        DATA_VALID;
    logic [31:0] DBG_PC;

    logic [31:0] rf_model  [32];
    logic [31:0] mem_model [1024];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          rd_pulses = 0;
    logic [9:0]  last_mem_addr = 10'd0;
    logic [11:0] cur_addr;

    always #5 CLK = ~CLK;

    debug_controller dut (
        .CLK        (CLK),
        .RST        (RST),
        .HLT        (HLT),
        .DBG_ADDR   (DBG_ADDR),
        .instr_done (instr_done),
        .pc_in      (pc_in),
        .rf_addr    (rf_addr),
        .rf_rdata   (rf_rdata),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .cpu_stall  (cpu_stall),
        .HALTED     (HALTED),
        .DATA       (DATA),
        .DATA_VALID (DATA_VALID),
        .DBG_PC     (DBG_PC)
    );

    // Environment: combinational register file, one-cycle memory that
    // presents garbage whenever no read was strobed.
    assign rf_rdata = rf_model[rf_addr];

    always @(posedge CLK) begin
        mem_rdata <= mem_rd_en ? mem_model[mem_addr] : 32'hDEAD_BEEF;
        if (mem_rd_en) begin
            rd_pulses     <= rd_pulses + 1;
            last_mem_addr <= mem_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Address-map model: edges from launch to result, and the result itself.
    function automatic int exp_lat(input logic [11:0] a);
        if (a < 12'h020)       return 2;
        else if (a <= 12'h41F) return 3;
        else                   return 1;
    endfunction

    function automatic logic [31:0] exp_val(input logic [11:0] a);
        logic [11:0] off;
        if (a < 12'h020) return rf_model[a[4:0]];
        if (a <= 12'h41F) begin
            off = a - 12'h020;
            return mem_model[off[9:0]];
        end
        return 32'd0;
    endfunction

    // DBG_ADDR already holds a and the next edge launches its read.
    task automatic read_check(input logic [11:0] a, input string tag);
        int   lat;
        int   p0;
        logic is_mem;
        logic [11:0] off;
        lat    = exp_lat(a);
        is_mem = (lat == 3);
        p0     = rd_pulses;
        if (lat > 1) begin
            step(1);
            check({tag, "_vclr"}, 32'(DATA_VALID), 32'd0);
            step(lat - 1);
        end else begin
            step(1);
        end
        check({tag, "_data"}, DATA, exp_val(a));
        check({tag, "_valid"}, 32'(DATA_VALID), 32'd1);
        check({tag, "_pulses"}, 32'(rd_pulses - p0), is_mem ? 32'd1 : 32'd0);
        if (is_mem) begin
            off = a - 12'h020;
            check({tag, "_maddr"}, 32'(last_mem_addr), 32'(off[9:0]));
        end
        cur_addr = a;
    endtask

    task automatic do_read(input logic [11:0] a);
        DBG_ADDR = a;
        read_check(a, $sformatf("rd%0h", a));
    endtask

    function automatic logic [11:0] rand_addr(input int region);
        case (region)
            0:       return 12'($urandom_range(0, 31));
            1:       return 12'($urandom_range(32, 1055));
            default: return 12'($urandom_range(1056, 4095));
        endcase
    endfunction

    function automatic logic [11:0] fresh(input logic [11:0] a);
        return (a == cur_addr) ? (a ^ 12'd1) : a;
    endfunction

    initial begin
        logic [11:0] a1;
        logic [11:0] a2;
        logic [31:0] pc;
        logic        seen_halt;

        for (int i = 0; i < 32; i++)   rf_model[i]  = $urandom;
        for (int i = 0; i < 1024; i++) mem_model[i] = $urandom;
        rf_model[31] = 32'h0000_00AB;

        // Reset with HLT held high: the halt request must be ignored.
        RST = 1'b1; HLT = 1'b1; DBG_ADDR = 12'd0; instr_done = 1'b0; pc_in = 32'd0;
        cur_addr = 12'd0;
        step(3);
        check("rst_stall",  32'(cpu_stall),  32'd0);
        check("rst_halted", 32'(HALTED),     32'd0);
        check("rst_data",   DATA,            32'd0);
        check("rst_valid",  32'(DATA_VALID), 32'd0);
        check("rst_pc",     DBG_PC,          32'd0);
        check("rst_mrd",    32'(mem_rd_en),  32'd0);

        // First edge without reset and HLT=1 enters DRAIN.
        RST = 1'b0;
        step(1);
        check("drain_stall",  32'(cpu_stall), 32'd1);
        check("drain_halted", 32'(HALTED),    32'd0);
        step(2);
        check("drain_wait", 32'(HALTED), 32'd0);
        instr_done = 1'b1; pc_in = 32'h0000_0040;
        step(1);
        instr_done = 1'b0; pc_in = $urandom;
        check("halt_halted", 32'(HALTED), 32'd1);
        check("halt_pc",     DBG_PC,      32'h0000_0040);

        // Entry read of the current address, then a register read.
        read_check(12'd0, "entry0");
        do_read(12'd31);

        // Sweep across the register/memory boundary every 5 cycles.
        for (int a = 32; a <= 38; a++) begin
            do_read(12'(a));
            step(5 - exp_lat(12'(a)));
        end

        do_read(12'h420);

        // Random reads spread over all three regions.
        for (int i = 0; i < 24; i++) begin
            do_read(fresh(rand_addr(int'($urandom_range(0, 2)))));
        end

        // Address change mid-read: first read completes, then a new one runs.
        a1 = fresh(rand_addr(1));
        a2 = rand_addr(0);
        if (a2 == a1) a2 = 12'd5;
        DBG_ADDR = a1;
        step(1);
        DBG_ADDR = a2;
        step(2);
        check("chg_first", DATA, exp_val(a1));
        check("chg_fv",    32'(DATA_VALID), 32'd1);
        step(1);
        check("chg_vclr",  32'(DATA_VALID), 32'd0);
        step(1);
        check("chg_second", DATA, exp_val(a2));
        cur_addr = a2;

        // HLT dropped during a memory read: read finishes, then run resumes.
        a1 = fresh(rand_addr(1));
        DBG_ADDR = a1;
        step(1);
        HLT = 1'b0;
        step(2);
        check("rel_data",   DATA,         exp_val(a1));
        check("rel_halted", 32'(HALTED),  32'd1);
        step(1);
        check("rel_run_h",  32'(HALTED),    32'd0);
        check("rel_run_s",  32'(cpu_stall), 32'd0);
        cur_addr = a1;

        // Halt request with no retiring instruction.
        HLT = 1'b1; pc = $urandom; pc_in = pc;
        step(1);
        check("rh_stall", 32'(cpu_stall), 32'd1);
`ifdef DBG_DRAIN_TIMEOUT_EN
        step(15);
        check("to_before", 32'(HALTED), 32'd0);
        step(1);
        check("to_halted", 32'(HALTED), 32'd1);
        check("to_pc",     DBG_PC,      pc);
`else
        seen_halt = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (HALTED) seen_halt = 1'b1;
        end
        check("nto_halted", 32'(seen_halt), 32'd0);
        instr_done = 1'b1;
        step(1);
        instr_done = 1'b0;
        check("nto_halt", 32'(HALTED), 32'd1);
        check("nto_pc",   DBG_PC,      pc);
`endif
        read_check(cur_addr, "entry2");

        // Reset in the middle of a memory read.
        a1 = fresh(rand_addr(1));
        DBG_ADDR = a1;
        step(2);
        RST = 1'b1;
        step(1);
        check("mrst_stall",  32'(cpu_stall),  32'd0);
        check("mrst_halted", 32'(HALTED),     32'd0);
        check("mrst_data",   DATA,            32'd0);
        check("mrst_valid",  32'(DATA_VALID), 32'd0);
        check("mrst_pc",     DBG_PC,          32'd0);
        check("mrst_mrd",    32'(mem_rd_en),  32'd0);
        step(1);
        check("mrst_hlt_ign", 32'(cpu_stall), 32'd0);
        RST = 1'b0;
        step(1);
        check("mrst_drain", 32'(cpu_stall), 32'd1);
        pc = $urandom; pc_in = pc; instr_done = 1'b1;
        step(1);
        instr_done = 1'b0;
        check("mrst_halt", 32'(HALTED), 32'd1);
        check("mrst_pc2",  DBG_PC,      pc);
        read_check(a1, "entry3");

        // Release from IDLE.
        HLT = 1'b0;
        step(1);
        check("idle_rel_s", 32'(cpu_stall), 32'd0);
        check("idle_rel_h", 32'(HALTED),    32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
